// File: rtl/vram_pkg.sv
// Shared VRAM constants and the sync engine state encoding.
package vram_pkg;
    localparam int VRAM_ADDR_W = 12;
    localparam int VRAM_DATA_W = 32;
    localparam int VRAM_RD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        DRAIN = 2'd2
    } sync_state_t;
endpackage

// File: rtl/vram_sync_pipe.sv
// Delay line that carries {valid, addr} of each source read until its data returns.
module vram_sync_pipe #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              vld_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              pipe_fill
);
    logic [RD_LAT-1:0] vld_p;
    logic [ADDR_W-1:0] addr_p [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < RD_LAT; i++) addr_p[i] <= '0;
        end else begin
            vld_p[0]  <= vld_in;
            addr_p[0] <= addr_in;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                addr_p[i] <= addr_p[i-1];
            end
        end
    end

    // True while a read is still in flight behind the output stage.
    always_comb begin
        pipe_fill = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) pipe_fill = pipe_fill | vld_p[i];
    end

    assign vld_out  = vld_p[RD_LAT-1];
    assign addr_out = addr_p[RD_LAT-1];
endmodule

// File: rtl/vram_sync.sv
// Copies the CPU-facing VRAM into the PPU-facing VRAM as one linear burst at vblank start.
module vram_sync
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int RD_LAT = VRAM_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sync_req,
    input  logic              i_vblank_start,
    output logic              o_sync_busy,
    output logic              o_sync_pending,
    output logic              o_sync_done,
    output logic              o_src_rden,
    output logic [ADDR_W-1:0] o_src_addr,
    input  logic [DATA_W-1:0] i_src_rddata,
    output logic              o_dst_wren,
    output logic [ADDR_W-1:0] o_dst_addr,
    output logic [DATA_W-1:0] o_dst_wrdata
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    sync_state_t       state, state_nxt;
    logic              pending_q;
    logic              done_q, done_nxt;
    logic [ADDR_W-1:0] cnt_q;
    logic              pipe_fill;
    logic              start;

    assign start = (state == IDLE) && i_vblank_start && (pending_q || i_sync_req);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = COPY;
            COPY:  if (cnt_q == LAST_ADDR) state_nxt = DRAIN;
            DRAIN: begin
                // Exit as the final write leaves the delay line.
                if (!pipe_fill) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            if (start)
                pending_q <= 1'b0;
            else if (i_sync_req)
                pending_q <= 1'b1;
            if (start)
                cnt_q <= '0;
            else if (state == COPY && cnt_q != LAST_ADDR)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_src_rden     = (state == COPY);
    assign o_src_addr     = cnt_q;
    assign o_sync_busy    = (state != IDLE);
    assign o_sync_pending = pending_q;
    assign o_sync_done    = done_q;

    vram_sync_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_in    (o_src_rden),
        .addr_in   (o_src_addr),
        .vld_out   (o_dst_wren),
        .addr_out  (o_dst_addr),
        .pipe_fill (pipe_fill)
    );

    assign o_dst_wrdata = o_dst_wren ? i_src_rddata : '0;
endmodule

// File: doc/vram_sync.md
# vram_sync

VRAM synchronisation engine sitting directly upstream of the dual VRAM block: it copies the CPU-facing VRAM into the PPU-facing VRAM during vertical blank. The CPU edits its VRAM freely during the frame and requests a sync; the engine performs one full linear copy at the next vblank start, so the PPU only ever sees complete frames. It drives the read port of the CPU-facing VRAM and the write port of the PPU-facing VRAM.

## Interface
Parameters:
- ADDR_W, 12, VRAM word-address width; copy length N = 2**ADDR_W words.
- DATA_W, 32, VRAM word width.
- RD_LAT, 2, source read latency in cycles (≥1).

Ports:
- clk  in  1  system clock, one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- i_sync_req  in  1  one-cycle pulse from the CPU-side register requesting a sync.
- i_vblank_start  in  1  one-cycle pulse from the PPU timing generator.
- o_sync_busy  out  1  high while a copy is in flight.
- o_sync_pending  out  1  a request is latched and awaiting vblank.
- o_sync_done  out  1  one-cycle pulse after the last word is written.
- o_src_rden  out  1  CPU-VRAM read enable.
- o_src_addr  out  ADDR_W  CPU-VRAM read address.
- i_src_rddata  in  DATA_W  CPU-VRAM read data, valid RD_LAT cycles after address/enable.
- o_dst_wren  out  1  PPU-VRAM write enable.
- o_dst_addr  out  ADDR_W  PPU-VRAM write address.
- o_dst_wrdata  out  DATA_W  PPU-VRAM write data.

## Operation
- States: IDLE, COPY, DRAIN.
- Pending flag: set by i_sync_req in any state; cleared when COPY is entered. Request arriving during COPY/DRAIN stays pending for the next vblank.
- IDLE → COPY when i_vblank_start is high and (pending or i_sync_req same cycle). Vblank with nothing pending: no action.
- COPY: read counter runs 0..N-1, one read per cycle, o_src_rden=1, o_src_addr=counter. After issuing N-1 → DRAIN.
- Delay line of RD_LAT stages carries (valid, addr) of each read; its output drives o_dst_wren/o_dst_addr. o_dst_wrdata = i_src_rddata (combinational pass-through).
- DRAIN: no reads; waits until delay line empty, then pulses o_sync_done and → IDLE.
- Counter wrap: counter is ADDR_W bits; terminal detect on N-1, never wraps to 0 inside a copy.
- i_vblank_start during COPY/DRAIN: ignored.
- Reset (incl. mid-copy): state IDLE, pending cleared, delay line cleared, all outputs 0, no done pulse; partially copied PPU-VRAM contents are left as is.

## Timing
- Reset values: every output 0.
- i_vblank_start sampled at edge of cycle k (start condition true): o_src_rden high cycles k+1..k+N, o_src_addr = c-(k+1) in cycle c.
- o_dst_wren high cycles k+1+RD_LAT..k+N+RD_LAT, o_dst_addr equals the address issued RD_LAT cycles earlier.
- o_sync_busy high k+1..k+N+RD_LAT; o_sync_done high only in cycle k+N+RD_LAT+1; o_sync_pending low from k+1 (unless re-requested).
- Total copy: N+RD_LAT cycles from vblank to last write; no bubbles.

## Structure
- Shared package vram_pkg: VRAM_ADDR_W, VRAM_DATA_W, VRAM_RD_LAT constants and the sync_state_t enum (IDLE, COPY, DRAIN).
- One sub-module: vram_sync_pipe, RD_LAT-deep shift register of {valid, addr} with async clear.
- Top holds FSM, pending flag, read counter and output registers.

## Test plan
Bench parameters ADDR_W=4 (N=16), RD_LAT=2, source model returns data = addr ^ 32'hA5A5_0000.
- Pulse i_sync_req, then i_vblank_start at cycle 10 → reads addr 0..15 in cycles 11..26, writes 0..15 in cycles 13..28 with data addr^A5A5_0000, o_sync_done only in cycle 29.
- i_vblank_start with no request → no rden/wren, busy stays 0 for 40 cycles.
- i_sync_req and i_vblank_start same cycle in IDLE → copy starts next cycle, pending never observed high after start.
- i_sync_req at cycle 15 during copy → pending high through end; second copy starts only on the next vblank pulse; extra vblank at cycle 20 ignored.
- rst_n low at cycle 18 mid-copy → all outputs 0 immediately, no done pulse; after release a new request+vblank performs a full 16-word copy.
- Scoreboard check: destination memory equals source after each done, exactly 16 writes per copy, no duplicate addresses.
